// File: rtl/vga_draw_pkg.sv
// Shared types and helpers for the VGA drawing engines.
//
// Contents:
//   draw_state_e  - engine FSM states (idle, drawing, done pulse)
//   rect_cmd_t    - one rectangle command (two corners, colour, outline flag)
//   clip_coord()  - clamp a coordinate to an inclusive upper limit
//
// Display geometry macros default to 640x480 when the build does not supply them.

`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 9
`endif

package vga_draw_pkg;

    // Widest colour the command struct can carry; narrower colours are zero-extended.
    localparam int unsigned MaxRgbW = 24;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone
    } draw_state_e;

    typedef struct packed {
        logic [`H_SIZE-1:0] x0;
        logic [`H_SIZE-1:0] x1;
        logic [`V_SIZE-1:0] y0;
        logic [`V_SIZE-1:0] y1;
        logic [MaxRgbW-1:0] colour;
        logic               outline;
    } rect_cmd_t;

    function automatic int unsigned clip_coord(input int unsigned v, input int unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command and frame-buffer source bus of the rectangle fill engine.
//
// Signals:
//   cmd_valid/cmd_ready             command handshake
//   cmd_x0/x1, cmd_y0/y1, cmd_color rectangle corners (any order) and fill colour
//   cmd_outline                     border-only drawing (VGA_RECT_OUTLINE_EN builds only)
//   done, busy                      engine status
//   src_write/src_rdy               pixel write handshake to the frame buffer
//   src_x, src_y, src_writedata     pixel address and data
// Modports: master = drawing engine, slave = command source / frame buffer side.
// Optional macro: VGA_RECT_OUTLINE_EN.

interface vga_rect_fill_if #(
    parameter int unsigned RGB_SIZE = 12,
    parameter int unsigned SRAM_DW  = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [`H_SIZE-1:0]  cmd_x0;
    logic [`H_SIZE-1:0]  cmd_x1;
    logic [`V_SIZE-1:0]  cmd_y0;
    logic [`V_SIZE-1:0]  cmd_y1;
    logic [RGB_SIZE-1:0] cmd_color;
`ifdef VGA_RECT_OUTLINE_EN
    logic                cmd_outline;
`endif
    logic                done;
    logic                busy;
    logic                src_write;
    logic [`H_SIZE-1:0]  src_x;
    logic [`V_SIZE-1:0]  src_y;
    logic [SRAM_DW-1:0]  src_writedata;
    logic                src_rdy;

    modport master (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
`ifdef VGA_RECT_OUTLINE_EN
        input  cmd_outline,
`endif
        input  src_rdy,
        output cmd_ready, done, busy, src_write, src_x, src_y, src_writedata
    );

    modport slave (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
`ifdef VGA_RECT_OUTLINE_EN
        output cmd_outline,
`endif
        output src_rdy,
        input  cmd_ready, done, busy, src_write, src_x, src_y, src_writedata
    );
endinterface

// File: rtl/vga_rect_walker.sv
// Raster-order coordinate walker for the rectangle fill engine.
//
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   load                 capture bounds, start at (xl, yt)
//   xl, xr, yt, yb       already ordered and clipped bounds
//   outline              middle rows visit only xl and xr
//   advance              current pixel accepted, step to the next one
//   x, y                 current pixel
//   last                 current pixel is the final one of the rectangle

module vga_rect_walker #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 9
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          load,
    input  logic [HW-1:0] xl,
    input  logic [HW-1:0] xr,
    input  logic [VW-1:0] yt,
    input  logic [VW-1:0] yb,
    input  logic          outline,
    input  logic          advance,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          last
);
    logic [HW-1:0] x_q, x_d, xl_q, xr_q;
    logic [VW-1:0] y_q, y_d, yt_q, yb_q;
    logic          outline_q;
    logic          middle_row;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x_q       <= '0;
            y_q       <= '0;
            xl_q      <= '0;
            xr_q      <= '0;
            yt_q      <= '0;
            yb_q      <= '0;
            outline_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (load) begin
                xl_q      <= xl;
                xr_q      <= xr;
                yt_q      <= yt;
                yb_q      <= yb;
                outline_q <= outline;
            end
        end
    end

    // Equality compares only: the walker stops at the bounds and never wraps.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        middle_row = outline_q && (y_q != yt_q) && (y_q != yb_q);
        if (load) begin
            x_d = xl;
            y_d = yt;
        end else if (advance) begin
            if (x_q != xr_q) begin
                // Outline middle rows skip the interior.
                x_d = (middle_row && (x_q == xl_q)) ? xr_q : x_q + HW'(1);
            end else if (y_q != yb_q) begin
                x_d = xl_q;
                y_d = y_q + VW'(1);
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == xr_q) && (y_q == yb_q);
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: accepts one rectangle command and writes its pixels to the
// frame buffer source port in raster order, one pixel per accepted beat.
//
// Ports:
//   sys_clk   system clock
//   sys_rst   synchronous active-high reset
//   bus       vga_rect_fill_if.master (command handshake, status, src_* write port)
// Parameters: RGB_SIZE (colour width), SRAM_DW (write data width, >= RGB_SIZE),
//             H_MAX/V_MAX (visible size; coordinates clip to H_MAX-1/V_MAX-1).
// Optional macro: VGA_RECT_OUTLINE_EN adds cmd_outline (border-only drawing).

module vga_rect_fill
    import vga_draw_pkg::*;
#(
    parameter int unsigned RGB_SIZE = 12,
    parameter int unsigned SRAM_DW  = 16,
    parameter int unsigned H_MAX    = `H_DISPLAY,
    parameter int unsigned V_MAX    = `V_DISPLAY
) (
    input logic             sys_clk,
    input logic             sys_rst,
    vga_rect_fill_if.master bus
);
    localparam int unsigned HW = `H_SIZE;
    localparam int unsigned VW = `V_SIZE;

    draw_state_e        state_q, state_d;
    rect_cmd_t          cmd;
    logic [SRAM_DW-1:0] wdata_q;
    logic [HW-1:0]      xl_raw, xr_raw, xl_c, xr_c, walk_x;
    logic [VW-1:0]      yt_raw, yb_raw, yt_c, yb_c, walk_y;
    logic               load, advance, last;
    logic               cmd_ready, src_write, done;

    always_comb begin
        cmd        = '0;
        cmd.x0     = bus.cmd_x0;
        cmd.x1     = bus.cmd_x1;
        cmd.y0     = bus.cmd_y0;
        cmd.y1     = bus.cmd_y1;
        cmd.colour = MaxRgbW'(bus.cmd_color[RGB_SIZE-1:0]);
`ifdef VGA_RECT_OUTLINE_EN
        cmd.outline = bus.cmd_outline;
`else
        cmd.outline = 1'b0;
`endif
    end

    // Order the corners, then clip to the visible area.
    always_comb begin
        xl_raw = (cmd.x0 < cmd.x1) ? cmd.x0 : cmd.x1;
        xr_raw = (cmd.x0 < cmd.x1) ? cmd.x1 : cmd.x0;
        yt_raw = (cmd.y0 < cmd.y1) ? cmd.y0 : cmd.y1;
        yb_raw = (cmd.y0 < cmd.y1) ? cmd.y1 : cmd.y0;
        xl_c   = HW'(clip_coord(32'(xl_raw), H_MAX - 1));
        xr_c   = HW'(clip_coord(32'(xr_raw), H_MAX - 1));
        yt_c   = VW'(clip_coord(32'(yt_raw), V_MAX - 1));
        yb_c   = VW'(clip_coord(32'(yb_raw), V_MAX - 1));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // Upper colour bits are zero, so this is the zero-extended colour.
                wdata_q <= SRAM_DW'(cmd.colour);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        advance   = 1'b0;
        cmd_ready = 1'b0;
        src_write = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                src_write = 1'b1;
                if (bus.src_rdy) begin
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    vga_rect_walker #(
        .HW(HW),
        .VW(VW)
    ) u_walker (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (load),
        .xl      (xl_c),
        .xr      (xr_c),
        .yt      (yt_c),
        .yb      (yb_c),
        .outline (cmd.outline),
        .advance (advance),
        .x       (walk_x),
        .y       (walk_y),
        .last    (last)
    );

    assign bus.cmd_ready     = cmd_ready;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = done;
    assign bus.src_write     = src_write;
    assign bus.src_x         = walk_x;
    assign bus.src_y         = walk_y;
    assign bus.src_writedata = wdata_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed self-checking bench for vga_rect_fill.

module tb_vga_rect_fill;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    vga_rect_fill_if #(.RGB_SIZE(12), .SRAM_DW(16)) bus ();

    vga_rect_fill #(
        .RGB_SIZE (12),
        .SRAM_DW  (16),
        .H_MAX    (640),
        .V_MAX    (480)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int bx[$];
    int by[$];
    int bd[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [11:0] col, input bit outl);
        bus.cmd_x0    = `H_SIZE'(x0);
        bus.cmd_x1    = `H_SIZE'(x1);
        bus.cmd_y0    = `V_SIZE'(y0);
        bus.cmd_y1    = `V_SIZE'(y1);
        bus.cmd_color = col;
`ifdef VGA_RECT_OUTLINE_EN
        bus.cmd_outline = outl;
`else
        if (outl) $display("outline request ignored in this build");
`endif
    endtask

    // Issue a command with src_rdy high, collect beats until done.
    // ncyc counts cycles with the accept cycle as 1.
    task automatic draw_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [11:0] col, input bit outl, output int ncyc);
        bit got_done;
        bx.delete();
        by.delete();
        bd.delete();
        @(negedge sys_clk);
        set_cmd(x0, y0, x1, y1, col, outl);
        bus.cmd_valid = 1'b1;
        bus.src_rdy   = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.cmd_valid = 1'b0;
        ncyc     = 2;
        got_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.src_write && bus.src_rdy) begin
                bx.push_back(int'(bus.src_x));
                by.push_back(int'(bus.src_y));
                bd.push_back(int'(bus.src_writedata));
            end
            @(posedge sys_clk);
            #1;
            ncyc++;
        end
        check_eq("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check_eq("write_low_in_done", 32'(bus.src_write), 32'd0);
            @(posedge sys_clk);
            #1;
            check_eq("done_one_cycle", 32'(bus.done), 32'd0);
            check_eq("ready_after_done", 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    task automatic check_beats(input string tag, input int ex[$], input int ey[$]);
        int errs = 0;
        check_eq({tag, "_count"}, 32'(bx.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < bx.size(); i++) begin
            if (bx[i] != ex[i] || by[i] != ey[i]) errs++;
        end
        check_eq({tag, "_order"}, 32'(errs), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        int ex[$];
        int ey[$];
        int errs;
        bit seen;

        bus.cmd_valid = 1'b0;
        bus.src_rdy   = 1'b0;
        set_cmd(0, 0, 0, 0, 12'h000, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_src_write", 32'(bus.src_write), 32'd0);
        check_eq("rst_src_x", 32'(bus.src_x), 32'd0);
        check_eq("rst_src_y", 32'(bus.src_y), 32'd0);
        check_eq("rst_wdata", 32'(bus.src_writedata), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk);

        // Basic 3x2 fill.
        ex = '{2, 3, 4, 2, 3, 4};
        ey = '{3, 3, 3, 4, 4, 4};
        draw_rect(2, 3, 4, 4, 12'hABC, 1'b0, ncyc);
        check_beats("fill", ex, ey);
        check_eq("fill_wdata_first", 32'(bd[0]), 32'h0ABC);
        check_eq("fill_wdata_last", 32'(bd[5]), 32'h0ABC);
        check_eq("fill_cycles", 32'(ncyc), 32'd8);

        // Swapped corners give the same sequence.
        draw_rect(4, 4, 2, 3, 12'hABC, 1'b0, ncyc);
        check_beats("swap", ex, ey);
        check_eq("swap_cycles", 32'(ncyc), 32'd8);

        // Single pixel with three stall cycles.
        @(negedge sys_clk);
        set_cmd(5, 5, 5, 5, 12'h123, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.src_rdy   = 1'b0;
        @(posedge sys_clk);
        #1;
        bus.cmd_valid = 1'b0;
        check_eq("stall_busy", 32'(bus.busy), 32'd1);
        check_eq("stall_not_ready", 32'(bus.cmd_ready), 32'd0);
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            if (!bus.src_write || bus.src_x != 5 || bus.src_y != 5
                || bus.src_writedata != 16'h0123 || bus.done) errs++;
            @(posedge sys_clk);
            #1;
        end
        check_eq("stall_held", 32'(errs), 32'd0);
        bus.src_rdy = 1'b1;
        check_eq("stall_beat_write", 32'(bus.src_write), 32'd1);
        check_eq("stall_beat_x", 32'(bus.src_x), 32'd5);
        @(posedge sys_clk);
        #1;
        check_eq("stall_one_beat", 32'(bus.src_write), 32'd0);
        check_eq("stall_done", 32'(bus.done), 32'd1);
        @(posedge sys_clk);
        #1;

        // Clipping at the bottom-right corner.
        ex.delete();
        ey.delete();
        for (int y = 470; y <= 479; y++) begin
            for (int x = 630; x <= 639; x++) begin
                ex.push_back(x);
                ey.push_back(y);
            end
        end
        draw_rect(630, 470, 700, 500, 12'hFFF, 1'b0, ncyc);
        check_beats("clip", ex, ey);
        errs = 0;
        foreach (bx[i]) if (bx[i] > 639 || by[i] > 479) errs++;
        check_eq("clip_range", 32'(errs), 32'd0);

        // Reset after two accepted beats.
        @(negedge sys_clk);
        set_cmd(2, 3, 4, 4, 12'hABC, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.src_rdy   = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("mid_x_before_rst", 32'(bus.src_x), 32'd4);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check_eq("mid_rst_write", 32'(bus.src_write), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) seen = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        check_eq("mid_rst_no_done", 32'(seen), 32'd0);
        ex = '{10, 11};
        ey = '{10, 10};
        draw_rect(11, 10, 10, 10, 12'h055, 1'b0, ncyc);
        check_beats("after_rst", ex, ey);
        check_eq("after_rst_wdata", 32'(bd[0]), 32'h0055);

`ifdef VGA_RECT_OUTLINE_EN
        ex = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
        ey = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
        draw_rect(0, 0, 3, 3, 12'h00F, 1'b1, ncyc);
        check_beats("outline", ex, ey);
        ex = '{7, 7, 7};
        ey = '{1, 2, 3};
        draw_rect(7, 1, 7, 3, 12'h00F, 1'b1, ncyc);
        check_beats("outline_col", ex, ey);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
